mem_access_ctrl: RTL and testbench

Load/store initiator that drives the word-wide data memory port (m_read, m_write, addr, d_in, d_out) on behalf of the CPU memory stage. Accepts one byte, halfword or word request at a time over a valid/ready handshake. Sub-word stores use read-modify-write; loads are byte-lane extracted and sign- or zero-extended. It returns exactly one single-cycle response per accepted request.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_access_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the load/store memory access controller.
//   - SZ_* request size encodings (byte/half/word/reserved)
//   - mem_state_e: controller FSM states
//   - CNT_W: width of the read-latency down-counter (RD_LAT up to 7)
//   - is_bad(): misalignment / reserved-size test, used when the
//     MISALIGN_TRAP_EN build option is defined.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } mem_state_e;

  // True when the access cannot be served: misaligned half/word or
  // the reserved size encoding.
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] a_lo);
    case (size)
      SZ_BYTE: is_bad = 1'b0;
      SZ_HALF: is_bad = a_lo[0];
      SZ_WORD: is_bad = (a_lo != 2'b00);
      default: is_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU-side request/response bundle of the controller.
//   Request : req_valid, req_ready, req_we, req_size, req_unsigned,
//             req_addr, req_wdata
//   Response: rsp_valid, rsp_rdata, err_misalign
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; the master must hold every req_* field stable
// while req_valid is high and req_ready is low. rsp_valid is a one-cycle
// strobe with no backpressure; rsp_rdata and err_misalign are only
// meaningful while rsp_valid is high.
//   master modport: CPU memory stage
//   slave  modport: mem_access_ctrl
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err_misalign;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, err_misalign
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, err_misalign
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational little-endian byte-lane steering.
//   size    in  request size (SZ_BYTE/SZ_HALF/anything else = word)
//   a_lo    in  address bits [1:0]
//   uns     in  1 = zero-extend loads, 0 = sign-extend
//   wdata   in  low 16 bits of store data (right-justified)
//   rword   in  word read from memory
//   st_word out rword with the target lane replaced by store data
//   ld_word out target lane shifted to bit 0 and extended
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  a_lo,
  input  logic        uns,
  input  logic [15:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] st_word,
  output logic [31:0] ld_word
);

  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    sh      = '0;
    b       = '0;
    h       = '0;
    st_word = rword;
    ld_word = rword;
    case (size)
      SZ_BYTE: begin
        sh      = {a_lo, 3'b000};
        b       = 8'(rword >> sh);
        st_word = (rword & ~(32'h0000_00FF << sh)) | ({24'h0, wdata[7:0]} << sh);
        ld_word = {{24{b[7] & ~uns}}, b};
      end
      SZ_HALF: begin
        sh      = {a_lo[1], 4'b0000};
        h       = 16'(rword >> sh);
        st_word = (rword & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata} << sh);
        ld_word = {{16{h[15] & ~uns}}, h};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store initiator for a word-wide data memory port.
// Serves one byte/half/word request at a time; sub-word stores are done
// as read-modify-write, loads are lane-extracted and extended.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          mem_access_ctrl_if.slave request/response bundle
//   m_read       memory read enable (RD and WAIT states)
//   m_write      memory write enable (WR state, one cycle)
//   addr         word-aligned memory address, latched at accept
//   d_in         memory write data, valid while m_write is high
//   d_out        memory read data, sampled on the last WAIT edge
//   state_dbg    current FSM state
// Parameter RD_LAT (1..7): cycles from the first m_read cycle until d_out
// is sampled.
// Build option MISALIGN_TRAP_EN: when defined, misaligned half/word and
// reserved-size requests get an err_misalign response with no memory
// access. When undefined, err_misalign is 0, the low address bits a
// half/word cannot use are ignored and size 11 behaves as word.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_ctrl_if.slave    bus,
  output logic                m_read,
  output logic                m_write,
  output logic [31:0]         addr,
  output logic [31:0]         d_in,
  input  logic [31:0]         d_out,
  output mem_state_e          state_dbg
);

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             uns_q;
  logic [1:0]       size_q;
  logic [1:0]       a_lo_q;
  logic [15:0]      wdata_q;
  logic [31:0]      rdata_q;

  logic             bad;
  logic [1:0]       size_eff;
  logic [1:0]       a_lo_eff;
  logic [31:0]      st_word;
  logic [31:0]      ld_word;

`ifdef MISALIGN_TRAP_EN
  assign bad      = is_bad(bus.req_size, bus.req_addr[1:0]);
  assign size_eff = bus.req_size;
  assign a_lo_eff = bus.req_addr[1:0];
`else
  // Without the trap every request is served: size 11 becomes a word and
  // the address bits below the access size are forced to zero.
  assign bad = 1'b0;
  always_comb begin
    size_eff = (bus.req_size == SZ_RSVD) ? SZ_WORD : bus.req_size;
    case (size_eff)
      SZ_HALF: a_lo_eff = {bus.req_addr[1], 1'b0};
      SZ_WORD: a_lo_eff = 2'b00;
      default: a_lo_eff = bus.req_addr[1:0];
    endcase
  end
`endif

  mem_lane_align u_align (
    .size    (size_q),
    .a_lo    (a_lo_q),
    .uns     (uns_q),
    .wdata   (wdata_q),
    .rword   (d_out),
    .st_word (st_word),
    .ld_word (ld_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      a_lo_q  <= 2'b00;
      wdata_q <= '0;
      rdata_q <= '0;
      addr    <= '0;
      d_in    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= size_eff;
            a_lo_q  <= a_lo_eff;
            wdata_q <= bus.req_wdata[15:0];
            addr    <= {bus.req_addr[31:2], 2'b00};
            rdata_q <= '0;
            if (bad) begin
              state <= RESP;
            end else if (bus.req_we && size_eff == SZ_WORD) begin
              // Full-word store needs no read; data goes straight out.
              d_in  <= bus.req_wdata;
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          cnt   <= CNT_W'(RD_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            // Last WAIT edge: d_out is valid now.
            if (we_q) begin
              d_in  <= st_word;
              state <= WR;
            end else begin
              rdata_q <= ld_word;
              state   <= RESP;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR: state <= RESP;
        RESP: begin
          rdata_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == IDLE && bus.req_valid) begin
      err_q <= bad;
    end else if (state == RESP) begin
      err_q <= 1'b0;
    end
  end
  assign bus.err_misalign = err_q;
`else
  assign bus.err_misalign = 1'b0;
`endif

  // Strobes decode straight from the state register so an asynchronous
  // reset removes them without waiting for a clock.
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign m_read        = (state == RD) || (state == WAIT);
  assign m_write       = (state == WR);
  assign state_dbg     = state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed scoreboard bench for mem_access_ctrl
// (RD_LAT = 1, memory word 0x10 preloaded with 0xDEADBEEF).
// Expectations for responses ({cycle, err, rdata}) and memory writes
// ({cycle, addr, data}) are queued by the driver; a monitor pops and
// compares them on every falling edge. Expectations for accesses with the
// trap option follow MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  import mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        m_read;
  logic        m_write;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic [31:0] d_out = '0;
  mem_state_e  state_dbg;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.RD_LAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .m_read    (m_read),
    .m_write   (m_write),
    .addr      (addr),
    .d_in      (d_in),
    .d_out     (d_out),
    .state_dbg (state_dbg)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:63];
  logic        preload = 1'b1;
  always @(posedge clk) begin
    if (preload) mem[4] <= 32'hDEAD_BEEF;
    else if (m_write) mem[addr[7:2]] <= d_in;
    if (m_read) d_out <= mem[addr[7:2]];
  end

  // ---------------- scoreboard ----------------
  logic [48:0] exp_q[$];   // {cycle[15:0], err, rdata}
  logic [79:0] wexp_q[$];  // {cycle[15:0], addr, data}
  int n_cmp = 0;
  int n_fail = 0;
  int rd_cnt = 0;

  localparam int LAT_ERR = 1;
  localparam int LAT_WST = 2;
  localparam int LAT_LD  = 3;
  localparam int LAT_SST = 4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_reads(input string name, input int base, input int exp);
    check(name, 32'(rd_cnt - base), 32'(exp));
  endtask

  task automatic run_monitor();
    logic [48:0] e;
    logic [79:0] w;
    forever begin
      @(negedge clk);
      if (m_read) rd_cnt++;
      if (m_read && m_write) begin
        n_cmp++;
        n_fail++;
        $display("FAIL strobe_overlap: cycle %0d m_read=1 m_write=1, required at most one high", cyc);
      end
      if (bus.rsp_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: cycle %0d err=%b rdata=%h, required no response",
                   cyc, bus.err_misalign, bus.rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if ({cyc[15:0], bus.err_misalign, bus.rsp_rdata} !== e) begin
            n_fail++;
            $display("FAIL rsp: got cycle=%0d err=%b rdata=%h, required cycle=%0d err=%b rdata=%h",
                     cyc[15:0], bus.err_misalign, bus.rsp_rdata, e[48:33], e[32], e[31:0]);
          end
        end
      end
      if (m_write) begin
        n_cmp++;
        if (wexp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected: cycle %0d addr=%h d_in=%h, required no write", cyc, addr, d_in);
        end else begin
          w = wexp_q.pop_front();
          if ({cyc[15:0], addr, d_in} !== w) begin
            n_fail++;
            $display("FAIL wr: got cycle=%0d addr=%h d_in=%h, required cycle=%0d addr=%h d_in=%h",
                     cyc[15:0], addr, d_in, w[79:64], w[63:32], w[31:0]);
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int lat,
                      input bit track, input bit keep, output int acc);
    int guard;
    logic [15:0] rc;
    guard = 0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready 0 for %0d cycles, required 1", guard);
    end
    acc = cyc;
    rc  = cyc[15:0] + 16'(lat);
    if (track) exp_q.push_back({rc, exp_err, exp_rd});
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic expect_write(input int c, input logic [31:0] a, input logic [31:0] d);
    wexp_q.push_back({c[15:0], a, d});
  endtask

  task automatic wait_done(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || wexp_q.size() != 0) && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: %0d responses and %0d writes pending, required 0",
               name, exp_q.size(), wexp_q.size());
      exp_q.delete();
      wexp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int acc2;
    int base;
    fork
      run_monitor();
    join_none

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = SZ_BYTE;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_strobes", {28'b0, bus.rsp_valid, bus.err_misalign, m_read, m_write}, 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_d_in", d_in, 32'h0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    rst_n   = 1'b1;
    preload = 1'b0;

    // Loads from 0xDEADBEEF at 0x10
    base = rd_cnt;
    send(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("ld_b_s13");
    check_reads("ld_b_s13_reads", base, 2);
    send(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'h0000_DEAD, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("ld_h_u12");
    send(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("ld_h_s10");
    send(1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, 32'h0000_00EF, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("ld_b_u10");
    send(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFBE, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("ld_b_s11");
    send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("ld_w_10");

    // Misaligned half, misaligned word, reserved size
    base = rd_cnt;
`ifdef MISALIGN_TRAP_EN
    send(1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, LAT_ERR, 1'b1, 1'b0, acc);
    wait_done("mis_h11");
    send(1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, LAT_ERR, 1'b1, 1'b0, acc);
    wait_done("mis_w12");
    send(1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, LAT_ERR, 1'b1, 1'b0, acc);
    wait_done("rsvd");
    send(1'b1, SZ_HALF, 1'b0, 32'h13, 32'h1111, 32'h0, 1'b1, LAT_ERR, 1'b1, 1'b0, acc);
    wait_done("mis_st_h13");
    check_reads("mis_reads", base, 0);
`else
    send(1'b0, SZ_HALF, 1'b0, 32'h11, 32'h0, 32'hFFFF_BEEF, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("mis_h11");
    send(1'b0, SZ_WORD, 1'b0, 32'h12, 32'h0, 32'hDEAD_BEEF, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("mis_w12");
    send(1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("rsvd");
    check_reads("mis_reads", base, 6);
`endif

    // Reset during WAIT of a byte store: dropped, no write, no response
    send(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h55, 32'h0, 1'b0, 0, 1'b0, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_state", {29'b0, state_dbg}, {29'b0, WAIT});
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", {30'b0, m_read, m_write}, 32'd0);
    check("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("after_rst_ld");

    // Byte store 0x55 to 0x11 (upper data bits must be ignored)
    base = rd_cnt;
    send(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000_AA55, 32'h0, 1'b0, LAT_SST, 1'b1, 1'b0, acc);
    expect_write(acc + 3, 32'h10, 32'hDEAD_55EF);
    wait_done("st_b11");
    check_reads("st_b11_reads", base, 2);
    send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEAD_55EF, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("ld_after_st_b");

    // Half store 0x1234 to 0x12
    send(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h9999_1234, 32'h0, 1'b0, LAT_SST, 1'b1, 1'b0, acc);
    expect_write(acc + 3, 32'h10, 32'h1234_55EF);
    wait_done("st_h12");
    send(1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0, 32'h0000_0034, 1'b0, LAT_LD, 1'b1, 1'b0, acc);
    wait_done("ld_b_s12");

    // Word store 0xCAFEBABE to 0x20: no read, write in cycle 1
    base = rd_cnt;
    send(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFE_BABE, 32'h0, 1'b0, LAT_WST, 1'b1, 1'b0, acc);
    expect_write(acc + 1, 32'h20, 32'hCAFE_BABE);
    wait_done("st_w20");
    check_reads("st_w20_reads", base, 0);

    // Byte store to top lane of 0x20
    send(1'b1, SZ_BYTE, 1'b0, 32'h23, 32'h0000_0001, 32'h0, 1'b0, LAT_SST, 1'b1, 1'b0, acc);
    expect_write(acc + 3, 32'h20, 32'h01FE_BABE);
    wait_done("st_b23");

    // Back-to-back with req_valid held high
    send(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h01FE_BABE, 1'b0, LAT_LD, 1'b1, 1'b1, acc);
    send(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1234_55EF, 1'b0, LAT_LD, 1'b1, 1'b0, acc2);
    check("b2b_accept_gap", 32'(acc2 - acc), 32'd4);
    wait_done("b2b");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
